// File: rtl/cmd_rx_assembler.sv
// UART receiver (8N1) feeding a two-byte command assembler.
// Two consecutive good bytes form cmd = {first, second}. The assembler drops back
// to expecting a high byte on a framing error, or when the gap between bytes is too long.
module cmd_rx_assembler #(
  parameter int unsigned BAUD_DIV  = 2604,
  parameter int unsigned TO_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err
);

  localparam int unsigned BW = $clog2(BAUD_DIV + 1);
  localparam int unsigned TW = $clog2(TO_CYCLES + 1);
  localparam logic [BW-1:0] BAUD_FULL = BW'(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE    = TW'(1);

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_e;
  typedef enum logic {WAIT_HI, WAIT_LO} asm_state_e;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [BW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_vld_q, byte_vld_d;
  logic            frm_err_q, frm_err_d;
  asm_state_e      asm_state_q, asm_state_d;
  logic [7:0]      hi_q, hi_d;
  logic [TW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [15:0]     cmd_q, cmd_d;
  logic            cmd_rdy_q, cmd_rdy_d;

  logic            rx_fall;
  logic            sample;
  logic            start_ok;
  logic            set_rdy;
  logic            clr_rdy;

  assign rx_fall  = rx_prev_q & ~rx_sync_q;
  assign sample   = (rx_state_q == RX_RECV) && (baud_cnt_q <= BAUD_ONE);
  assign start_ok = sample && (bit_cnt_q == 4'd0) && !rx_sync_q;

  // Two-flop synchronizer plus previous-value flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver next state: mid-bit sampling of start, 8 data bits LSB first, stop
  always_comb begin
    rx_state_d = rx_state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_vld_d = 1'b0;
    frm_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_RECV;
          baud_cnt_d = BAUD_HALF;
          bit_cnt_d  = 4'd0;
        end
      end
      RX_RECV: begin
        if (sample) begin
          baud_cnt_d = BAUD_FULL;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0) begin
            if (rx_sync_q) begin
              rx_state_d = RX_IDLE;
            end
          end else if (bit_cnt_q == 4'd9) begin
            rx_state_d = RX_IDLE;
            if (rx_sync_q) begin
              byte_vld_d = 1'b1;
            end else begin
              frm_err_d = 1'b1;
            end
          end else begin
            shift_d = {rx_sync_q, shift_q[7:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt_q - BAUD_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_vld_q <= byte_vld_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // Assembler next state: pair bytes, inter-byte timeout, ready flag
  always_comb begin
    asm_state_d = asm_state_q;
    hi_d        = hi_q;
    idle_cnt_d  = idle_cnt_q;
    cmd_d       = cmd_q;
    set_rdy     = 1'b0;
    case (asm_state_q)
      WAIT_HI: begin
        if (byte_vld_q) begin
          hi_d        = shift_q;
          idle_cnt_d  = '0;
          asm_state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (byte_vld_q) begin
          cmd_d       = {hi_q, shift_q};
          set_rdy     = 1'b1;
          asm_state_d = WAIT_HI;
        end else if (rx_state_q == RX_IDLE) begin
          if (idle_cnt_q >= TO_LAST) begin
            asm_state_d = WAIT_HI;
          end else begin
            idle_cnt_d = idle_cnt_q + TO_ONE;
          end
        end
      end
      default: asm_state_d = WAIT_HI;
    endcase
    if (frm_err_q) begin
      asm_state_d = WAIT_HI;
    end
    // A new command only clears the flag once its start bit is confirmed at
    // mid-bit, so a line glitch cannot drop an unread command.
    clr_rdy = clr_cmd_rdy || (start_ok && (asm_state_q == WAIT_HI));
    if (set_rdy) begin
      cmd_rdy_d = 1'b1;
    end else if (clr_rdy) begin
      cmd_rdy_d = 1'b0;
    end else begin
      cmd_rdy_d = cmd_rdy_q;
    end
  end

  // Assembler state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_state_q <= WAIT_HI;
      hi_q        <= '0;
      idle_cnt_q  <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
    end else begin
      asm_state_q <= asm_state_d;
      hi_q        <= hi_d;
      idle_cnt_q  <= idle_cnt_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_cmd_rx_assembler.sv
// Scoreboard bench for cmd_rx_assembler: directed UART frames, queued expected commands.
module tb_cmd_rx_assembler;

  localparam int unsigned BD = 16;
  localparam int unsigned TO = 1000;

  logic        clk;
  logic        rst_n;
  logic        RX;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_rdy = 0;
  int frm_seen = 0;
  int frm_exp = 0;
  logic [15:0] exp_q[$];

  logic        rdy_prev = 1'b0;
  logic [15:0] cmd_prev = '0;
  logic        frm_prev = 1'b0;

  cmd_rx_assembler #(
    .BAUD_DIV (BD),
    .TO_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .frm_err    (frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop expected command whenever a new one is presented; count frm_err pulses
  always @(negedge clk) begin
    if (frm_err) begin
      frm_seen = frm_seen + 1;
      if (frm_prev) begin
        total = total + 1;
        bad = bad + 1;
        $display("FAIL frm_err_width act=2+cycles exp=1 cycle");
      end
    end
    if (cmd_rdy && (!rdy_prev || cmd != cmd_prev)) begin
      t_rdy = cyc;
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL cmd_unexpected act=%h exp=none", cmd);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (cmd !== e) begin
          bad = bad + 1;
          $display("FAIL cmd_word act=%h exp=%h", cmd, e);
        end
      end
    end
    rdy_prev = cmd_rdy;
    cmd_prev = cmd;
    frm_prev = frm_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    RX = v;
    repeat (BD) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    if (!stop) begin
      drive_bit(1'b1);
      drive_bit(1'b1);
    end
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle(input string name);
    idle(4);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int t_start;
    rst_n = 1'b0;
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd", cmd, 16'h0000);
    check("rst_rdy", cmd_rdy, 0);
    check("rst_frm", frm_err, 0);
    rst_n = 1'b1;
    idle(5);

    // 0x00,0x01 back-to-back with latency window
    exp_q.push_back(16'h0001);
    t_start = cyc;
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    settle("drain_0001");
    check("latency_ok", ((t_rdy - t_start) >= 19 * BD) && ((t_rdy - t_start) <= 20 * BD + 8), 1);
    check("frm_none", frm_seen, 0);

    // acknowledge, then A5,3C
    check("rdy_before_clr", cmd_rdy, 1);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
    check("rdy_after_clr", cmd_rdy, 0);
    check("cmd_after_clr", cmd, 16'h0001);
    exp_q.push_back(16'hA53C);
    send_byte(8'hA5, 1'b1);
    idle(3 * BD);
    send_byte(8'h3C, 1'b1);
    settle("drain_A53C");

    // set beats simultaneous clear
    clr_cmd_rdy = 1'b1;
    exp_q.push_back(16'h5AC3);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    settle("drain_5AC3");
    check("rdy_clr_held", cmd_rdy, 0);
    clr_cmd_rdy = 1'b0;

    // framing error discards the high byte
    frm_exp = frm_exp + 1;
    send_byte(8'h12, 1'b0);
    idle(2 * BD);
    check("frm_once", frm_seen, frm_exp);
    check("cmd_kept_frm", cmd, 16'h5AC3);
    exp_q.push_back(16'h0002);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    settle("drain_0002");

    // inter-byte timeout discards the high byte
    send_byte(8'h55, 1'b1);
    idle(TO + 200);
    check("cmd_kept_to", cmd, 16'h0002);
    exp_q.push_back(16'h0003);
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    settle("drain_0003");

    // gap well inside the timeout still pairs
    exp_q.push_back(16'h6677);
    send_byte(8'h66, 1'b1);
    idle(TO / 2);
    send_byte(8'h77, 1'b1);
    settle("drain_6677");

    // short glitch while idle
    RX = 1'b0;
    repeat (BD / 4) @(posedge clk);
    #1;
    idle(3 * BD);
    check("glitch_rdy", cmd_rdy, 1);
    check("glitch_cmd", cmd, 16'h6677);
    check("glitch_frm", frm_seen, frm_exp);
    exp_q.push_back(16'h0005);
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
    settle("drain_0005");

    // reset mid second byte
    send_byte(8'h00, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_cmd", cmd, 16'h0000);
    check("midrst_rdy", cmd_rdy, 0);
    check("midrst_frm", frm_err, 0);
    RX = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2 * BD);
    exp_q.push_back(16'h0004);
    send_byte(8'h00, 1'b1);
    send_byte(8'h04, 1'b1);
    settle("drain_0004");
    check("frm_total", frm_seen, frm_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_rx_assembler.md
CMD_RX_ASSEMBLER -- requirements
Module: cmd_rx_assembler

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, clocks per UART bit (50 MHz / 19200 baud).
REQ-002 SHALL have parameter TO_CYCLES, default 65536, maximum clocks allowed between first-byte stop sample and second-byte start edge.
REQ-003 SHALL have port clk, input, 1, system clock; one clock, all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port RX, input, 1, asynchronous serial line from the command master; idle high.
REQ-006 SHALL have port clr_cmd_rdy, input, 1, consumer acknowledge; clears cmd_rdy.
REQ-007 SHALL have port cmd, output, 16, last complete command word, {first byte, second byte}.
REQ-008 SHALL have port cmd_rdy, output, 1, high while an unacknowledged command is held in cmd.
REQ-009 SHALL have port frm_err, output, 1, one-cycle pulse on a bad stop bit.

Function
REQ-010 SHALL pass RX through two flops (both reset to 1) before any use; all RX references below mean the synchronized value.
REQ-011 Receiver SHALL use states IDLE and RECV; IDLE -> RECV on synchronized RX falling edge (previous 1, current 0).
REQ-012 On entering RECV, baud counter SHALL load BAUD_DIV/2 (integer divide), then reload BAUD_DIV after every sample; bit counter SHALL start at 0.
REQ-013 SHALL take 10 samples per frame: start, 8 data bits LSB first into a shift register, stop.
REQ-014 If start sample is 1 (glitch), receiver SHALL return to IDLE with no byte, no frm_err, assembler state unchanged.
REQ-015 Stop sample 1 SHALL produce an internal byte-valid pulse, one cycle, in the cycle after the stop sample; receiver returns to IDLE the same cycle.
REQ-016 Stop sample 0 SHALL pulse frm_err for one cycle, discard the byte, and force assembler to WAIT_HI.
REQ-017 Assembler SHALL use states WAIT_HI and WAIT_LO; reset state WAIT_HI.
REQ-018 In WAIT_HI, byte-valid SHALL latch byte into an 8-bit high register and go to WAIT_LO; cmd unchanged.
REQ-019 In WAIT_LO, byte-valid SHALL load cmd = {high register, byte}, set cmd_rdy the next cycle, return to WAIT_HI.
REQ-020 In WAIT_LO, an idle counter SHALL count clocks while the receiver is in IDLE; reaching TO_CYCLES SHALL return assembler to WAIT_HI, discard the high byte, no output change.
REQ-021 cmd SHALL hold its value until the next complete command; it SHALL NOT change on partial, errored, or timed-out frames.
REQ-022 cmd_rdy SHALL clear on clr_cmd_rdy high, or on a start edge accepted while in WAIT_HI (new command beginning).
REQ-023 If command completion and clr_cmd_rdy occur in the same cycle, set SHALL win (cmd_rdy = 1).
REQ-024 A new command completing while cmd_rdy is already 1 SHALL overwrite cmd; cmd_rdy stays 1.
REQ-025 Latency: cmd_rdy SHALL rise exactly 1 clock after the second byte's stop sample, roughly 19.5 x BAUD_DIV clocks after the first start edge for back-to-back bytes.
REQ-026 Counters SHALL be sized to hold BAUD_DIV and TO_CYCLES without wrap; bit counter 4 bits.

Reset
REQ-027 On rst_n low, asynchronously: cmd = 16'h0000, cmd_rdy = 0, frm_err = 0, receiver IDLE, assembler WAIT_HI, counters 0, synchronizer flops 1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release the first falling edge SHALL start a fresh frame treated as a high byte.

Verification
REQ-029 Send bytes 0x00,0x01 back-to-back -> cmd = 16'h0001, cmd_rdy = 1 one clock after second stop sample; frm_err never pulses.
REQ-030 With cmd_rdy = 1, pulse clr_cmd_rdy one cycle -> cmd_rdy = 0 next cycle, cmd still 16'h0001; then send 0xA5,0x3C -> cmd = 16'hA53C.
REQ-031 Send 0x12 with stop bit forced 0 -> one-cycle frm_err; then send 0x00,0x02 -> cmd = 16'h0002 (no 0x12 in high byte).
REQ-032 Send 0x55, hold RX high 70000 clocks, send 0x00,0x03 -> cmd = 16'h0003, not 16'h5500.
REQ-033 Drive RX low for BAUD_DIV/4 clocks while idle -> no byte, no frm_err, cmd_rdy and state unchanged.
REQ-034 Assert rst_n low after 5 bits of the second byte of 0x00,0x01 -> all outputs at reset values; a subsequent 0x00,0x04 -> cmd = 16'h0004.
